// File: rtl/memory_arbiter_pkg.sv
// Shared types and constants for the memory_arbiter slice.
// Holds the FSM state enum and the round-robin pointer helper.
package memory_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RELEASE = 2'd2
    } arb_state_t;

    localparam int unsigned HOST_MASTER = 0;
    localparam int unsigned MAX_MASTERS = 8;
    localparam int unsigned PTR_WIDTH   = $clog2(MAX_MASTERS);

    // Pointer moves one past the winner; masters 1..num_masters-1 form the ring.
    function automatic logic [PTR_WIDTH-1:0] next_rr_ptr(
        input logic [PTR_WIDTH-1:0] winner,
        input int unsigned          num_masters
    );
        int unsigned nxt;
        nxt = 32'(winner) + 32'd1;
        return (nxt >= num_masters) ? PTR_WIDTH'(1) : PTR_WIDTH'(nxt);
    endfunction

endpackage

// File: rtl/memory_arbiter_rr_picker.sv
// arbiter_rr_picker: combinational winner selection for memory_arbiter.
// Host master has fixed priority; the rest are searched round-robin from rr_ptr.
module arbiter_rr_picker
    import memory_arbiter_pkg::*;
#(
    parameter int unsigned NUM_MASTERS = 3
) (
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [PTR_WIDTH-1:0]   rr_ptr,
    output logic [NUM_MASTERS-1:0] grant,
    output logic [PTR_WIDTH-1:0]   winner_idx
);

    logic        found;
    int unsigned slot;

    always_comb begin
        grant      = '0;
        winner_idx = '0;
        found      = 1'b0;
        slot       = 0;
        if (req[HOST_MASTER]) begin
            grant[HOST_MASTER] = 1'b1;
            found              = 1'b1;
        end
        // Ring of non-host masters wraps from NUM_MASTERS-1 back to index 1.
        for (int unsigned k = 0; k < NUM_MASTERS - 1; k++) begin
            slot = 32'(rr_ptr) + k;
            if (slot >= NUM_MASTERS) begin
                slot = slot - (NUM_MASTERS - 1);
            end
            for (int unsigned j = 1; j < NUM_MASTERS; j++) begin
                if (!found && (slot == j) && req[j]) begin
                    grant[j]   = 1'b1;
                    winner_idx = PTR_WIDTH'(j);
                    found      = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/memory_arbiter.sv
// memory_arbiter: Wishbone-classic arbiter sharing one slave, one locked transaction per grant.
// Define ARBITER_TIMEOUT_EN to abort a BUSY transaction after TIMEOUT_CYCLES without s_ack_i.
module memory_arbiter
    import memory_arbiter_pkg::*;
#(
    parameter int unsigned NUM_MASTERS    = 3,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [NUM_MASTERS-1:0]            m_cyc_i,
    input  logic [NUM_MASTERS-1:0]            m_stb_i,
    input  logic [NUM_MASTERS-1:0]            m_we_i,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr_i,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_data_i,
    output logic [DATA_WIDTH-1:0]             m_data_o,
    output logic [NUM_MASTERS-1:0]            m_ack_o,
    output logic [NUM_MASTERS-1:0]            m_err_o,
    output logic                              s_cyc_o,
    output logic                              s_stb_o,
    output logic                              s_we_o,
    output logic [ADDR_WIDTH-1:0]             s_addr_o,
    output logic [DATA_WIDTH-1:0]             s_data_o,
    input  logic [DATA_WIDTH-1:0]             s_data_i,
    input  logic                              s_ack_i,
    output logic [NUM_MASTERS-1:0]            grant_o,
    output logic                              busy_o
);

    arb_state_t             state_q, state_d;
    logic [NUM_MASTERS-1:0] grant_q, grant_d;
    logic [PTR_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;
    logic [NUM_MASTERS-1:0] req;
    logic [NUM_MASTERS-1:0] pick_grant;
    logic [PTR_WIDTH-1:0]   pick_idx;
    logic                   in_busy;
    logic                   owner_cyc;
    logic                   timeout_hit;

`ifdef ARBITER_TIMEOUT_EN
    localparam int unsigned CNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    assign timeout_hit = in_busy && (cnt_q == CNT_WIDTH'(TIMEOUT_CYCLES)) && !s_ack_i;
`else
    assign timeout_hit = 1'b0;
`endif

    assign req       = m_cyc_i & m_stb_i;
    assign in_busy   = (state_q == BUSY);
    assign owner_cyc = |(m_cyc_i & grant_q);
    assign m_data_o  = s_data_i;

    arbiter_rr_picker #(
        .NUM_MASTERS(NUM_MASTERS)
    ) u_picker (
        .req       (req),
        .rr_ptr    (rr_ptr_q),
        .grant     (pick_grant),
        .winner_idx(pick_idx)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            rr_ptr_q <= PTR_WIDTH'(1);
`ifdef ARBITER_TIMEOUT_EN
            cnt_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
`ifdef ARBITER_TIMEOUT_EN
            cnt_q    <= cnt_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
`ifdef ARBITER_TIMEOUT_EN
        cnt_d    = cnt_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d = BUSY;
                    grant_d = pick_grant;
                    // Host grants leave the ring position untouched.
                    if (!pick_grant[HOST_MASTER]) begin
                        rr_ptr_d = next_rr_ptr(pick_idx, NUM_MASTERS);
                    end
`ifdef ARBITER_TIMEOUT_EN
                    cnt_d = '0;
`endif
                end
            end
            BUSY: begin
                if (s_ack_i || !owner_cyc || timeout_hit) begin
                    state_d = RELEASE;
                end
`ifdef ARBITER_TIMEOUT_EN
                cnt_d = cnt_q + 1'b1;
`endif
            end
            RELEASE: begin
                state_d = IDLE;
                grant_d = '0;
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_comb begin
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        s_we_o   = 1'b0;
        s_addr_o = '0;
        s_data_o = '0;
        for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
            if (in_busy && grant_q[i]) begin
                s_cyc_o  = m_cyc_i[i];
                s_stb_o  = m_stb_i[i];
                s_we_o   = m_we_i[i];
                s_addr_o = m_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
                s_data_o = m_data_i[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        m_ack_o = (in_busy && s_ack_i) ? grant_q : '0;
        m_err_o = timeout_hit ? grant_q : '0;
        grant_o = grant_q;
        busy_o  = (state_q != IDLE);
    end

endmodule
